pipelined_addsub: RTL

//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 16-bit ripple-carry adder.
//  - Operand width is split into STAGES equal slices; one slice resolves per clock, with the carry registered between stages.
//  - Valid/ready handshake on both sides; sustains one operation per cycle.
//  - Adds subtract mode and a signed-overflow flag.
//  - Sits between operand-producing logic and the result consumer.

---
 rtl/addsub_pkg.sv | 44 ++++
 rtl/rca_slice.sv | 35 +++
 rtl/pipelined_addsub.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and arithmetic reference for the
// pipelined add/subtract unit.
package addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;
   localparam int MAX_W      = 64;

   // Returns {ovf, cout, sum} for a w-bit operation, sum zero-extended.
   function automatic logic [MAX_W+1:0] ref_addsub(
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b,
      input logic             cin,
      input logic             sub,
      input int               w
   );
      logic [MAX_W:0]   one;
      logic [MAX_W:0]   top;
      logic [MAX_W:0]   mask;
      logic [MAX_W:0]   full;
      logic [MAX_W:0]   low;
      logic [MAX_W-1:0] bm;
      logic             c0;
      logic             cout;
      logic             cmsb;
      one     = '0;
      one[0]  = 1'b1;
      top     = one << w;
      mask    = top - one;
      bm      = (sub == MODE_SUB) ? ~b : b;
      c0      = (sub == MODE_SUB) ? ~cin : cin;
      full    = ({1'b0, a} & mask) + ({1'b0, bm} & mask)
              + {{MAX_W{1'b0}}, c0};
      low     = ({1'b0, a} & (mask >> 1)) + ({1'b0, bm} & (mask >> 1))
              + {{MAX_W{1'b0}}, c0};
      cout    = |(full & top);
      cmsb    = |(low & (top >> 1));
      return {cmsb ^ cout, cout, full[MAX_W-1:0] & mask[MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/rca_slice.sv
// rca_slice: combinational ripple-carry adder for one pipeline slice;
// also exposes the carry into its top bit for overflow detection.
module rca_slice
   import addsub_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   always_comb begin
      logic c;
      c        = cin;
      sum      = '0;
      c_msb_in = cin;
      for (int i = 0; i < SLICE; i++) begin
         c_msb_in = c;
         sum[i]   = a[i] ^ b[i] ^ c;
         c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

   always_comb begin
      assert ({c_msb_in ^ cout, cout, MAX_W'(sum)} ==
              ref_addsub(MAX_W'(a), MAX_W'(b), cin, MODE_ADD, SLICE))
         else $error("rca_slice result differs from reference");
   end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: operand register followed by STAGES slice adders;
// skew registers carry pending operand slices, deskew the finished sums.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SLICE = WIDTH / STAGES;

   logic             en;
   logic             op_vld_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_d, opb_q;
   logic             c0_d, c0_q;

   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   // Subtract is folded in up front: A - B - cin == A + ~B + ~cin.
   assign opb_d = (in_sub == MODE_SUB) ? ~in_b : in_b;
   assign c0_d  = (in_sub == MODE_SUB) ? ~in_cin : in_cin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_vld_q <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         c0_q     <= 1'b0;
      end else if (en) begin
         op_vld_q <= in_valid;
         opa_q    <= in_a;
         opb_q    <= opb_d;
         c0_q     <= c0_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int DONE = (k + 1) * SLICE;

      logic [SLICE-1:0] sa, sb, ss;
      logic             sc, sco, smsb;
      logic             vld_d, vld_q, cy_q;
      logic [DONE-1:0]  sum_d, sum_q;

      if (k == 0) begin : g_src
         assign sa    = opa_q[SLICE-1:0];
         assign sb    = opb_q[SLICE-1:0];
         assign sc    = c0_q;
         assign vld_d = op_vld_q;
         assign sum_d = ss;
      end else begin : g_src
         assign sa    = g_stg[k-1].g_skew.skew_a_q[SLICE-1:0];
         assign sb    = g_stg[k-1].g_skew.skew_b_q[SLICE-1:0];
         assign sc    = g_stg[k-1].cy_q;
         assign vld_d = g_stg[k-1].vld_q;
         assign sum_d = {ss, g_stg[k-1].sum_q};
      end

      rca_slice #(
         .SLICE(SLICE)
      ) u_rca (
         .a       (sa),
         .b       (sb),
         .cin     (sc),
         .sum     (ss),
         .cout    (sco),
         .c_msb_in(smsb)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (en) begin
            vld_q <= vld_d;
            cy_q  <= sco;
            sum_q <= sum_d;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         localparam int REM = WIDTH - DONE;

         logic [REM-1:0] skew_a_d, skew_a_q;
         logic [REM-1:0] skew_b_d, skew_b_q;

         if (k == 0) begin : g_in
            assign skew_a_d = opa_q[WIDTH-1:SLICE];
            assign skew_b_d = opb_q[WIDTH-1:SLICE];
         end else begin : g_in
            assign skew_a_d =
               g_stg[k-1].g_skew.skew_a_q[REM+SLICE-1:SLICE];
            assign skew_b_d =
               g_stg[k-1].g_skew.skew_b_q[REM+SLICE-1:SLICE];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skew_a_q <= '0;
               skew_b_q <= '0;
            end else if (en) begin
               skew_a_q <= skew_a_d;
               skew_b_q <= skew_b_d;
            end
         end
      end

      // Only the top slice's MSB carry matters for signed overflow.
      if (k == STAGES - 1) begin : g_last
         logic ovf_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (en) begin
               ovf_q <= smsb ^ sco;
            end
         end
      end else begin : g_mid
         logic unused_msb;
         assign unused_msb = smsb;
      end
   end

   assign out_valid = g_stg[STAGES-1].vld_q;
   assign out_sum   = g_stg[STAGES-1].sum_q;
   assign out_cout  = g_stg[STAGES-1].cy_q;
   assign out_ovf   = g_stg[STAGES-1].g_last.ovf_q;

endmodule
